// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 sequencer.
// Optional LCD_LINE_WRAP_EN commands live here too.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT_LOAD,
      IDLE,
      SETUP,
      PULSE,
      EXEC
   } lcd_state_t;

   localparam int INIT_LEN = 4;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;

   function automatic logic [7:0] init_rom(input logic [1:0] k);
      case (k)
         2'd0:    init_rom = CMD_FUNC_SET;
         2'd1:    init_rom = CMD_DISP_ON;
         2'd2:    init_rom = CMD_ENTRY;
         default: init_rom = CMD_CLEAR;
      endcase
   endfunction

   function automatic int max2(input int a, input int b);
      max2 = (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: elapsed-cycle counter shared by all timed states.
// Held at zero by i_load; o_done marks the last cycle of the interval.
module lcd_delay_cnt #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_lim,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   assign o_done = (r_cnt == i_lim - W'(1));

   // count up; restart on reset, reload or end of interval
   always_ff @(posedge i_clk) begin
      if (i_rst || i_load || o_done) r_cnt <= '0;
      else                           r_cnt <= r_cnt + W'(1);
   end

endmodule

// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: HD44780 init + byte write sequencer.
// Define LCD_LINE_WRAP_EN for automatic line wrapping.
module lcd_seq_ctrl
   import lcd_pkg::*;
#(
   parameter int PWR_CYC      = 1500000,
   parameter int SETUP_CYC    = 4,
   parameter int E_CYC        = 25,
   parameter int CMD_WAIT_CYC = 4000,
   parameter int CLR_WAIT_CYC = 160000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       init_done,
   output logic       busy,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);

   localparam int MAXC = max2(max2(PWR_CYC, CLR_WAIT_CYC),
                              max2(CMD_WAIT_CYC, max2(SETUP_CYC, E_CYC)));
   localparam int CW   = $clog2(MAXC) + 1;

   lcd_state_t  r_state;
   logic        r_e;
   logic        r_rs;
   logic [7:0]  r_data;
   logic        r_ready;
   logic        r_init_done;
   logic        r_busy;
   logic [1:0]  r_k;

   logic [CW-1:0] w_lim;
   logic          w_timed;
   logic          w_done;
   logic          w_is_clr;

`ifdef LCD_LINE_WRAP_EN
   logic [4:0] r_col;
   logic       r_wrap;
   logic [7:0] r_wrap_cmd;
   logic [4:0] w_col_inc;

   assign w_col_inc = r_col + 5'd1;
`endif

   assign w_is_clr = ~r_rs & ((r_data == CMD_CLEAR) | (r_data == CMD_HOME));

   // pick the interval length of the current timed state
   always_comb begin
      w_lim   = CW'(SETUP_CYC);
      w_timed = 1'b1;
      case (r_state)
         PWR_WAIT: w_lim = CW'(PWR_CYC);
         SETUP:    w_lim = CW'(SETUP_CYC);
         PULSE:    w_lim = CW'(E_CYC);
         EXEC:     w_lim = w_is_clr ? CW'(CLR_WAIT_CYC) : CW'(CMD_WAIT_CYC);
         default:  w_timed = 1'b0;
      endcase
   end

   lcd_delay_cnt #(.W(CW)) u_cnt (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_load (~w_timed),
      .i_lim  (w_lim),
      .o_done (w_done)
   );

   // sequencer FSM with registered pin and handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= PWR_WAIT;
         r_e         <= 1'b0;
         r_rs        <= 1'b0;
         r_data      <= 8'h00;
         r_ready     <= 1'b0;
         r_init_done <= 1'b0;
         r_busy      <= 1'b1;
         r_k         <= 2'd0;
`ifdef LCD_LINE_WRAP_EN
         r_col       <= 5'd0;
         r_wrap      <= 1'b0;
         r_wrap_cmd  <= CMD_LINE1;
`endif
      end else begin
         case (r_state)
            PWR_WAIT: begin
               if (w_done) r_state <= INIT_LOAD;
            end
            INIT_LOAD: begin
               r_rs    <= 1'b0;
               r_data  <= init_rom(r_k);
               r_state <= SETUP;
            end
            IDLE: begin
               if (!r_ready) begin
                  r_ready <= 1'b1;
               end else if (req_valid) begin
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_rs    <= req_rs;
                  r_data  <= req_data;
                  r_state <= SETUP;
`ifdef LCD_LINE_WRAP_EN
                  if (req_rs) begin
                     r_col <= w_col_inc;
                     if (w_col_inc == 5'd16) begin
                        r_wrap     <= 1'b1;
                        r_wrap_cmd <= CMD_LINE2;
                     end else if (w_col_inc == 5'd0) begin
                        r_wrap     <= 1'b1;
                        r_wrap_cmd <= CMD_LINE1;
                     end
                  end else if (req_data == CMD_CLEAR || req_data == CMD_HOME) begin
                     r_col <= 5'd0;
                  end else if (req_data[7]) begin
                     r_col <= {req_data[6], req_data[3:0]};
                  end
`endif
               end
            end
            SETUP: begin
               if (w_done) begin
                  r_e     <= 1'b1;
                  r_state <= PULSE;
               end
            end
            PULSE: begin
               if (w_done) begin
                  r_e     <= 1'b0;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               if (w_done) begin
                  if (!r_init_done) begin
                     if (r_k == 2'(INIT_LEN - 1)) begin
                        r_init_done <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                     end else begin
                        r_k     <= r_k + 2'd1;
                        r_state <= INIT_LOAD;
                     end
                  end
`ifdef LCD_LINE_WRAP_EN
                  else if (r_wrap) begin
                     r_wrap  <= 1'b0;
                     r_rs    <= 1'b0;
                     r_data  <= r_wrap_cmd;
                     r_state <= SETUP;
                  end
`endif
                  else begin
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= PWR_WAIT;
         endcase
      end
   end

   assign req_ready = r_ready;
   assign init_done = r_init_done;
   assign busy      = r_busy;
   assign lcd_e     = r_e;
   assign lcd_rs    = r_rs;
   assign lcd_rw    = 1'b0;
   assign lcd_data  = r_data;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb_lcd_seq_ctrl: directed bench for lcd_seq_ctrl.
// Optional LCD_LINE_WRAP_EN section follows the same define.
module tb_lcd_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_rs;
   logic [7:0] req_data;
   logic       init_done;
   logic       busy;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int t0;
   int last_acc;
   int lat;

   logic [8:0] log_q[$];
   int         rise_q[$];
   logic       e_q = 1'b0;
   logic [8:0] held;
   int         wid = 0;
   int         bad_wid = 0;
   int         bad_stab = 0;
   int         bad_rw = 0;

   logic [7:0] exp_rom [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

   lcd_seq_ctrl #(
      .PWR_CYC      (20),
      .SETUP_CYC    (1),
      .E_CYC        (2),
      .CMD_WAIT_CYC (4),
      .CLR_WAIT_CYC (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rs    (req_rs),
      .req_data  (req_data),
      .init_done (init_done),
      .busy      (busy),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_data  (lcd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // pulse logger: records each E pulse and its bus contents
   always @(negedge clk) begin
      if (lcd_rw !== 1'b0) bad_rw++;
      if (lcd_e && !e_q) begin
         log_q.push_back({lcd_rs, lcd_data});
         rise_q.push_back(cyc);
         held = {lcd_rs, lcd_data};
         wid  = 1;
      end else if (lcd_e) begin
         wid++;
         if ({lcd_rs, lcd_data} !== held) bad_stab++;
      end else if (e_q && wid != 2 && !rst) begin
         bad_wid++;
      end
      e_q = lcd_e;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] log_at(input int i);
      return (i < log_q.size()) ? log_q[i] : 9'h1FF;
   endfunction

   function automatic int rise_at(input int i);
      return (i < rise_q.size()) ? rise_q[i] : -1;
   endfunction

   task automatic send(input logic rs, input logic [7:0] d,
                       input bit hold, output int l);
      int n;
      req_rs    = rs;
      req_data  = d;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      last_acc = cyc + 1;
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      n = 0;
      while (!req_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      l = cyc - last_acc;
   endtask

   task automatic chk_init(input string p);
      int n;
      n = 0;
      while (!init_done && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk({p, "_done_cyc"}, cyc - t0, 58);
      chk({p, "_npulse"}, log_q.size(), 4);
      for (int i = 0; i < 4; i++)
         chk({p, "_rom"}, log_at(i), {1'b0, exp_rom[i]});
      chk({p, "_rise0"}, rise_at(0) - t0, 22);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_rs    = 1'b0;
      req_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_e",     lcd_e,     0);
      chk("rst_rs",    lcd_rs,    0);
      chk("rst_rw",    lcd_rw,    0);
      chk("rst_data",  lcd_data,  0);
      chk("rst_ready", req_ready, 0);
      chk("rst_done",  init_done, 0);
      chk("rst_busy",  busy,      1);

      rst = 1'b0;
      t0  = cyc;
      repeat (5) @(negedge clk);
      req_rs    = 1'b1;
      req_data  = 8'h32;
      req_valid = 1'b1;
      chk_init("init1");
      chk("idle_busy", busy, 0);

      send(1'b1, 8'h32, 1'b0, lat);
      chk("held_acc", last_acc - t0, 60);
      chk("held_lat", lat, 8);
      chk("held_pulse", log_at(4), {1'b1, 8'h32});
      chk("held_rise", rise_at(4) - last_acc, 1);
      chk("held_npulse", log_q.size(), 5);

      log_q.delete();
      rise_q.delete();
      send(1'b1, 8'h32, 1'b1, lat);
      chk("b2b_lat0", lat, 8);
      send(1'b1, 8'h33, 1'b1, lat);
      chk("b2b_lat1", lat, 8);
      send(1'b1, 8'h2B, 1'b0, lat);
      chk("b2b_lat2", lat, 8);
      chk("b2b_npulse", log_q.size(), 3);
      chk("b2b_p0", log_at(0), {1'b1, 8'h32});
      chk("b2b_p1", log_at(1), {1'b1, 8'h33});
      chk("b2b_p2", log_at(2), {1'b1, 8'h2B});

      send(1'b0, 8'h01, 1'b0, lat);
      chk("clr_lat", lat, 14);
      send(1'b0, 8'h02, 1'b0, lat);
      chk("home_lat", lat, 14);
      send(1'b0, 8'h80, 1'b0, lat);
      chk("line1_lat", lat, 8);

      req_rs    = 1'b1;
      req_data  = 8'h41;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int n = 0; n < 20 && !lcd_e; n++) @(negedge clk);
      chk("pre_rst_e", lcd_e, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_e",     lcd_e,     0);
      chk("mid_rst_done",  init_done, 0);
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_busy",  busy,      1);
      @(negedge clk);
      rst = 1'b0;
      t0  = cyc;
      log_q.delete();
      rise_q.delete();
      chk_init("init2");

`ifdef LCD_LINE_WRAP_EN
      @(negedge clk);
      log_q.delete();
      rise_q.delete();
      for (int i = 0; i < 32; i++) begin
         send(1'b1, 8'h41 + 8'(i), 1'b0, lat);
         if (i == 15) chk("wrap16_lat", lat, 15);
      end
      chk("wrap_npulse", log_q.size(), 34);
      chk("wrap_p15", log_at(15), {1'b1, 8'h50});
      chk("wrap_line2", log_at(16), {1'b0, 8'hC0});
      chk("wrap_p17", log_at(17), {1'b1, 8'h51});
      chk("wrap_line1", log_at(33), {1'b0, 8'h80});
`endif

      repeat (3) @(negedge clk);
      chk("rw_low",   bad_rw,   0);
      chk("e_width",  bad_wid,  0);
      chk("e_stable", bad_stab, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
